// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//
// Pipelined carry-lookahead adder/subtractor for the MIPS datapath (ALU and
// address/branch adders).
//
// The WIDTH-bit operands are cut into STAGES equal segments of SEG = WIDTH/STAGES
// bits. Stage k adds segment k and registers the carry out of that segment for
// stage k+1. The already-summed low bits and the still-unused high operand bits
// travel with the token through the stage registers. Each segment is built from
// 4-bit CLA groups: the lookahead is flattened inside a group and the carry
// ripples from group to group.
//
// Stage 0 adds straight from the input ports, so with STAGES register levels
// the result is visible STAGES-1 edges after the accepting edge (STAGES=1
// gives a plain registered output).
//
// WIDTH must be a multiple of 4*STAGES, and STAGES must lie in 1..WIDTH/4.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand set valid
//   in_ready   out  1      operands accepted this cycle if in_valid
//   din1       in   WIDTH  operand A
//   din2       in   WIDTH  operand B
//   carry_in   in   1      carry (add) / borrow (sub) into bit 0
//   sub        in   1      0: A+B+carry_in, 1: A-B-carry_in
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes the result this cycle
//   dout       out  WIDTH  sum / difference
//   carry_out  out  1      carry out of the MSB (sub: 1 = no borrow)
//   overflow   out  1      two's-complement signed overflow
//   zero       out  1      dout == 0
// -----------------------------------------------------------------------------
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Adds one segment. The result is packed as
  // {carry into segment MSB, carry out of segment, SEG sum bits}.
  function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           cin);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    int             k;
    g    = a & b;
    p    = a | b;
    c    = '0;
    c[0] = cin;
    for (int j = 0; j < SEG / 4; j++) begin
      k = 4 * j;
      // Flattened lookahead inside the group, all carries from c[k].
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
             | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
             | (p[k+3] & p[k+2] & p[k+1] & g[k])
             | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
    end
    return {c[SEG-1], c[SEG], a ^ b ^ c[SEG-1:0]};
  endfunction

  // Stage registers
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             ovf_q;
  logic             zero_q;

  // Per-stage next state
  logic             v_d    [STAGES];
  logic [WIDTH-1:0] a_d    [STAGES];
  logic [WIDTH-1:0] b_d    [STAGES];
  logic [WIDTH-1:0] s_d    [STAGES];
  logic             c_d    [STAGES];
  logic             cin_w  [STAGES];
  logic [WIDTH-1:0] s_prev [STAGES];
  logic [SEG+1:0]   res    [STAGES];

  logic adv;

  // The whole pipeline moves as one; a stalled result freezes every stage.
  assign adv = ~v_q[LAST] | out_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // Subtraction is A + ~B + ~borrow.
        assign v_d[gi]    = in_valid;
        assign a_d[gi]    = din1;
        assign b_d[gi]    = sub ? ~din2 : din2;
        assign cin_w[gi]  = carry_in ^ sub;
        assign s_prev[gi] = '0;
      end else begin : g_next
        assign v_d[gi]    = v_q[gi-1];
        assign a_d[gi]    = a_q[gi-1];
        assign b_d[gi]    = b_q[gi-1];
        assign cin_w[gi]  = c_q[gi-1];
        assign s_prev[gi] = s_q[gi-1];
      end

      assign res[gi] = seg_add(a_d[gi][gi*SEG +: SEG], b_d[gi][gi*SEG +: SEG], cin_w[gi]);
      // Sum bits above the current segment are still zero, so OR-in is enough.
      assign s_d[gi] = s_prev[gi] | (WIDTH'(res[gi][SEG-1:0]) << (gi * SEG));
      assign c_d[gi] = res[gi][SEG];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        // The output stage only loads real tokens so bubbles never disturb
        // the visible result; inner stages may carry don't-care data.
        if (k != LAST || v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (v_d[LAST]) begin
        ovf_q  <= res[LAST][SEG+1] ^ res[LAST][SEG];
        zero_q <= ~|s_d[LAST];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign dout      = s_q[LAST];
  assign carry_out = c_q[LAST];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

  localparam int W   = 32;
  localparam int S   = 2;
  localparam int SEG = W / S;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din1;
  logic [W-1:0] din2;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  cla_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din1      (din1),
    .din2      (din2),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         co;
    logic         ov;
    logic         z;
    int           stage;
  } exp_t;

  exp_t q[$];
  int n_tests      = 0;
  int n_fail       = 0;
  int accepted     = 0;
  int dut_consumed = 0;
  int discarded    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: true integer arithmetic on wide values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    exp_t   e;
    longint ua, ub, sa, sbv, us, ss, lim, smax, smin, cil;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    cil  = longint'(ci);
    lim  = longint'(1) << W;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    if (!sb) begin
      us   = ua + ub + cil;
      ss   = sa + sbv + cil;
      e.co = (us >= lim);
    end else begin
      us   = ua - ub - cil;
      ss   = sa - sbv - cil;
      e.co = (ua >= ub + cil);
    end
    e.d     = us[W-1:0];
    e.ov    = (ss > smax) || (ss < smin);
    e.z     = (e.d == '0);
    e.stage = 0;
    return e;
  endfunction

  // Compare process: mid-cycle, inputs and outputs are stable.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_v;
    exp_v = (q.size() > 0) && (q[0].stage == S - 1);
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("in_ready", 64'(in_ready), 64'(!exp_v || out_ready));
    if (exp_v && out_valid) begin
      chk("dout", 64'(dout), 64'(q[0].d));
      chk("carry_out", 64'(carry_out), 64'(q[0].co));
      chk("overflow", 64'(overflow), 64'(q[0].ov));
      chk("zero", 64'(zero), 64'(q[0].z));
    end
    if (out_valid === 1'b1 && out_ready && !rst) dut_consumed++;
    if (rst) begin
      discarded += q.size();
      q.delete();
    end else if (!exp_v || out_ready) begin
      if (exp_v) void'(q.pop_front());
      foreach (q[i]) q[i].stage = q[i].stage + 1;
      if (in_valid) begin
        e = model(din1, din2, carry_in, sub);
        q.push_back(e);
        accepted++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((dut_consumed + discarded != accepted) && t < 50) begin
      step();
      t++;
    end
    chk(name, 64'(dut_consumed + discarded), 64'(accepted));
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb,
                          input logic [W-1:0] ed, input logic eco,
                          input logic eov, input logic ez);
    int t;
    step();
    din1 = a; din2 = b; carry_in = ci; sub = sb;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    din1 = W'($urandom); din2 = W'($urandom); carry_in = ~ci; sub = ~sb;
    t = 0;
    while (out_valid !== 1'b1 && t < 10) begin
      step();
      t++;
    end
    chk("dir_latency", 64'(t), 64'(S - 1));
    chk("dir_dout", 64'(dout), 64'(ed));
    chk("dir_carry_out", 64'(carry_out), 64'(eco));
    chk("dir_overflow", 64'(overflow), 64'(eov));
    chk("dir_zero", 64'(zero), 64'(ez));
    $display("[TB] %s %h %h ci=%0d -> %h co=%0d ov=%0d z=%0d", sb ? "sub" : "add",
             a, b, ci, dout, carry_out, overflow, zero);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      4:       v = W'((longint'(1) << SEG) - 1);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  logic [W-1:0] stream_a [8] = '{32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h80000000,
                                 32'h0000FFFF, 32'hDEADBEEF, 32'h7FFFFFFF, 32'h00000000};
  logic [W-1:0] stream_b [8] = '{32'h00000002, 32'h00000001, 32'h11111111, 32'h00000001,
                                 32'h00000001, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000001};
  logic [7:0]   stream_sub = 8'b0110_1010;
  logic [7:0]   stream_ci  = 8'b1001_0110;

  initial begin : main
    logic [W-1:0] held_d;
    logic         held_co, held_ov, held_z;
    rst = 1'b1; in_valid = 1'b0; din1 = '0; din2 = '0;
    carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_carry_out", 64'(carry_out), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    step();
    rst = 1'b0;

    // Hand-computed vectors
    directed(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    directed(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    directed(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
    directed(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    directed(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0);
    directed(32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
    directed(32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    directed(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    drain("dir_drain");

    // Back-to-back stream with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      step();
      din1 = stream_a[i]; din2 = stream_b[i];
      sub = stream_sub[i]; carry_in = stream_ci[i];
      in_valid = 1'b1; out_ready = 1'b1;
      chk("stream_in_ready", 64'(in_ready), 64'(1));
    end
    step();
    in_valid = 1'b0;
    drain("stream_drain");

    // Fill the pipeline with the consumer stalled, then hold for 3 cycles
    out_ready = 1'b0;
    for (int i = 0; i < S; i++) begin
      step();
      din1 = pick(); din2 = pick(); sub = 1'($urandom); carry_in = 1'($urandom);
      in_valid = 1'b1;
    end
    step();
    din1 = pick(); din2 = pick(); sub = 1'($urandom); carry_in = 1'($urandom);
    chk("stall_out_valid", 64'(out_valid), 64'(1));
    held_d = dout; held_co = carry_out; held_ov = overflow; held_z = zero;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_dout", 64'(dout), 64'(held_d));
      chk("stall_flags", 64'({carry_out, overflow, zero}), 64'({held_co, held_ov, held_z}));
      din1 = W'($urandom); din2 = W'($urandom);
    end
    out_ready = 1'b1;
    step();
    din1 = pick(); din2 = pick();
    step();
    drain("stall_drain");

    // Reset with two tokens in flight
    out_ready = 1'b0;
    step();
    din1 = 32'h00000003; din2 = 32'h00000004; sub = 1'b0; carry_in = 1'b0; in_valid = 1'b1;
    step();
    din1 = 32'h00000010; din2 = 32'h00000001; sub = 1'b1;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_quiet", 64'(out_valid), 64'(0));
    end

    // Random traffic with random stalls and bubbles
    for (int i = 0; i < 2000; i++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      din1 = pick(); din2 = pick();
      sub = 1'($urandom); carry_in = 1'($urandom);
    end
    step();
    drain("rand_drain");

    chk("token_balance", 64'(dut_consumed + discarded), 64'(accepted));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
